cla5_pipe_adder: RTL and testbench
==================================

CLA5_PIPE_ADDER -- requirements
Module: cla5_pipe_adder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: upstream offers an operand set.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts the operand set this cycle.
REQ-005 SHALL have port a, input, 5 bits: operand A, unsigned or two's complement.
REQ-006 SHALL have port b, input, 5 bits: operand B.
REQ-007 SHALL have port cin, input, 1 bit: carry-in.
REQ-008 SHALL have port out_valid, output, 1 bit: result presented.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream takes the result.
REQ-010 SHALL have port sum, output, 5 bits: registered sum.
REQ-011 SHALL have port cout, output, 1 bit: registered carry-out of bit 4.
REQ-012 SHALL have port ovf, output, 1 bit: registered signed overflow.

Function
REQ-013 SHALL implement a two-stage pipeline: S1 holds operand registers (a, b, cin, v1); S2 holds result registers (sum, cout, ovf, v2).
REQ-014 SHALL count an input handshake when in_valid && in_ready is sampled at a rising edge, and an output handshake when out_valid && out_ready is.
REQ-015 SHALL drive out_valid = v2, and drive sum, cout and ovf directly from S2 registers, with no combinational path from a, b or cin.
REQ-016 SHALL compute s2_accept = !v2 || out_ready, and in_ready = !v1 || s2_accept; in_ready SHALL be combinational from out_ready, v1 and v2 only.
REQ-017 SHALL load S1 from a, b and cin and set v1=1 on an input handshake; otherwise, when s2_accept, SHALL clear v1; otherwise SHALL hold S1.
REQ-018 SHALL, when s2_accept, load S2 with the CLA result of S1 and set v2=v1; otherwise SHALL hold S2 unchanged (stall).
REQ-019 SHALL compute the S1→S2 result as a carry-lookahead adder: g[i]=a[i]&b[i], p[i]=a[i]^b[i], and each c[i+1] a flat sum-of-products of g, p and cin (no ripple chain); sum[i]=p[i]^c[i]; cout=c[5].
REQ-020 SHALL compute ovf = c[5]^c[4].
REQ-021 SHALL have a latency of exactly 2 rising edges from the input handshake to out_valid=1 when out_ready is held at 1.
REQ-022 SHALL sustain a throughput of one result per cycle with out_ready=1, and SHALL allow an input handshake in the same cycle an output handshake occurs.
REQ-023 SHALL not drop, duplicate or reorder results under any out_ready pattern; maximum occupancy is 2 results.
REQ-024 SHALL hold out_valid, sum, cout and ovf stable while out_valid=1 and out_ready=0.
REQ-025 SHALL ignore a, b and cin when in_valid=0; S1 data SHALL NOT change without an input handshake.

Reset
REQ-026 SHALL, while rst=1 at a rising edge, clear v1, v2, sum, cout, ovf and S1 operands to 0; out_valid=0 on the cycle after.
REQ-027 SHALL hold in_ready=1 during and after reset.
REQ-028 SHALL discard any in-flight results on reset mid-operation.
REQ-029 SHALL ignore an input handshake presented in a cycle with rst=1.

Verification
REQ-030 Directed: a=13, b=9, cin=0, out_ready=1 -> 2 edges later out_valid=1, sum=22, cout=0, ovf=1.
REQ-031 Directed: a=31, b=1, cin=0 -> sum=0, cout=1, ovf=0; then a=15, b=0, cin=1 -> sum=16, cout=0, ovf=1.
REQ-032 Directed: back-to-back {(3,4,0),(31,31,1),(16,16,0)} with out_ready=1 -> results (7,0,0), (31,1,0), (0,1,1) on 3 consecutive cycles.
REQ-033 Directed: out_ready=0 for 4 cycles while in_valid=1 -> exactly 2 accepted, then in_ready=0 and outputs stable; release -> both drain in order, then in_ready=1.
REQ-034 Directed: rst=1 asserted with 2 results in flight -> next cycle out_valid=0, sum=0, in_ready=1; no stale result ever appears.
REQ-035 Directed: exhaustive 5-bit a × b × cin (2048 vectors) with random out_ready -> every result matches the {cout,sum} = a+b+cin reference and the ovf rule, in order.

Source files
------------

// File: rtl/cla5_pipe_adder.sv
// ============================================================================
//  Module   : cla5_pipe_adder
//  Purpose  : Two-stage valid/ready pipelined 5-bit carry-lookahead adder
//             with registered sum, carry-out and signed overflow.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cla5_pipe_adder (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] a,
    input  logic [4:0] b,
    input  logic       cin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] sum,
    output logic       cout,
    output logic       ovf
);

    // S1: operand registers
    logic [4:0] a_q;
    logic [4:0] b_q;
    logic       cin_q;
    logic       v1_q;

    // S2: result registers
    logic [4:0] sum_q;
    logic       cout_q;
    logic       ovf_q;
    logic       v2_q;

    logic       s2_accept;
    logic       in_hs;

    logic [4:0] g;
    logic [4:0] p;
    logic [5:0] c;
    logic [4:0] sum_d;
    logic       cout_d;
    logic       ovf_d;

    assign s2_accept = !v2_q || out_ready;
    assign in_ready  = !v1_q || s2_accept;
    assign in_hs     = in_valid && in_ready;

    assign g = a_q & b_q;
    assign p = a_q ^ b_q;

    // Each carry is a flat sum-of-products so no term depends on a lower carry.
    assign c[0] = cin_q;
    assign c[1] = g[0]
                | (p[0] & cin_q);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & cin_q);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin_q);
    assign c[4] = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin_q);
    assign c[5] = g[4]
                | (p[4] & g[3])
                | (p[4] & p[3] & g[2])
                | (p[4] & p[3] & p[2] & g[1])
                | (p[4] & p[3] & p[2] & p[1] & g[0])
                | (p[4] & p[3] & p[2] & p[1] & p[0] & cin_q);

    assign sum_d  = p ^ c[4:0];
    assign cout_d = c[5];
    assign ovf_d  = c[5] ^ c[4];

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= 5'd0;
            b_q    <= 5'd0;
            cin_q  <= 1'b0;
            v1_q   <= 1'b0;
            sum_q  <= 5'd0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            v2_q   <= 1'b0;
        end else begin
            if (in_hs) begin
                a_q   <= a;
                b_q   <= b;
                cin_q <= cin;
                v1_q  <= 1'b1;
            end else if (s2_accept) begin
                v1_q  <= 1'b0;
            end

            // S2 only advances when its current result is gone or leaving.
            if (s2_accept) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                v2_q   <= v1_q;
            end
        end
    end

    assign out_valid = v2_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_cla5_pipe_adder.sv
// ============================================================================
//  Module   : tb_cla5_pipe_adder
//  Purpose  : Directed and exhaustive self-checking bench for cla5_pipe_adder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cla5_pipe_adder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] a;
    logic [4:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] sum;
    logic       cout;
    logic       ovf;

    int total;
    int bad;

    cla5_pipe_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Result packed as {cout, sum, ovf}
    function automatic logic [6:0] ref_res(input logic [4:0] x, input logic [4:0] y, input logic ci);
        logic [5:0] full;
        logic       o;
        full = {1'b0, x} + {1'b0, y} + {5'd0, ci};
        o    = (x[4] == y[4]) && (full[4] != x[4]);
        return {full[5], full[4:0], o};
    endfunction

    // Directed stream: operands and hand-computed {cout,sum,ovf}
    logic [4:0] va [6] = '{5'd13, 5'd31, 5'd15, 5'd3, 5'd31, 5'd16};
    logic [4:0] vb [6] = '{5'd9,  5'd1,  5'd0,  5'd4, 5'd31, 5'd16};
    logic       vc [6] = '{1'b0,  1'b0,  1'b1,  1'b0, 1'b1,  1'b0};
    logic [6:0] ve [6] = '{{1'b0, 5'd22, 1'b1},
                           {1'b1, 5'd0,  1'b0},
                           {1'b0, 5'd16, 1'b1},
                           {1'b0, 5'd7,  1'b0},
                           {1'b1, 5'd31, 1'b0},
                           {1'b1, 5'd0,  1'b1}};

    logic [6:0] exp_q [$];
    logic [6:0] e;

    initial begin
        int idx;
        int budget;
        int acc;

        total = 0;
        bad   = 0;

        // Reset, with an input offer that must be ignored
        rst = 1'b1; in_valid = 1'b1; a = 5'd5; b = 5'd5; cin = 1'b0; out_ready = 1'b0;
        cyc(); cyc();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum",       {27'd0, sum},       32'd0);
        chk("rst_cout",      {31'd0, cout},      32'd0);
        chk("rst_ovf",       {31'd0, ovf},       32'd0);
        cyc(); cyc();
        chk("rst_ignored_hs", {31'd0, out_valid}, 32'd0);

        // Back-to-back directed stream with out_ready held high
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k < 6) begin
                in_valid = 1'b1; a = va[k]; b = vb[k]; cin = vc[k];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            @(posedge clk); #1;
            if (k == 0) begin
                chk("latency_not_early", {31'd0, out_valid}, 32'd0);
            end else begin
                chk("stream_valid", {31'd0, out_valid}, 32'd1);
                chk($sformatf("stream_res%0d", k - 1), {25'd0, cout, sum, ovf}, {25'd0, ve[k-1]});
            end
        end
        cyc();
        chk("stream_drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: four offers while stalled, only two fit
        out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; a = 5'(3 * k + 1); b = 5'(3 * k + 2); cin = k[0];
            #1;
            chk($sformatf("bp_in_ready%0d", k), {31'd0, in_ready}, (k < 2) ? 32'd1 : 32'd0);
            if (in_ready) acc++;
            @(posedge clk); #1;
            if (k >= 1) begin
                chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
                chk("bp_hold_res", {25'd0, cout, sum, ovf}, {25'd0, 1'b0, 5'd3, 1'b0});
            end
        end
        chk("bp_accepted", acc, 32'd2);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("bp_drain2_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_drain2_res", {25'd0, cout, sum, ovf}, {25'd0, 1'b0, 5'd10, 1'b0});
        cyc();
        chk("bp_empty_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_empty_ready", {31'd0, in_ready}, 32'd1);

        // Reset with two results in flight
        out_ready = 1'b0;
        in_valid = 1'b1; a = 5'd7; b = 5'd6; cin = 1'b1;
        cyc();
        a = 5'd2; b = 5'd2; cin = 1'b0;
        cyc();
        rst = 1'b1; a = 5'd9; b = 5'd9;
        cyc();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_sum",   {27'd0, sum},       32'd0);
        chk("midrst_ready", {31'd0, in_ready},  32'd1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("midrst_no_stale", {31'd0, out_valid}, 32'd0);
        end

        // Exhaustive a x b x cin with random out_ready, scoreboard in order
        idx    = 0;
        budget = 20000;
        while ((idx < 2048 || exp_q.size() != 0) && budget > 0) begin
            out_ready = 1'($urandom_range(0, 1));
            if (idx < 2048) begin
                in_valid = 1'b1;
                a   = idx[10:6];
                b   = idx[5:1];
                cin = idx[0];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("exh_unexpected", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("exh_res", {25'd0, cout, sum, ovf}, {25'd0, e});
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_res(a, b, cin));
                idx++;
            end
            @(posedge clk); #1;
            budget--;
        end
        chk("exh_timeout", budget > 0 ? 32'd1 : 32'd0, 32'd1);
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
